// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use/RAW hazard detection, operand forwarding, flush and stall counter.
module id_ex_hazard_stage #(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5,
  parameter int CtrlWidth  = 12,
  parameter int ForwardEn  = 1,
  parameter int CntWidth   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [DataWidth-1:0]  id_pc,
  input  logic [CtrlWidth-1:0]  id_ctrl,
  input  logic                  id_load,
  input  logic                  id_reg_write,
  input  logic [RegAddress-1:0] id_rs1,
  input  logic [RegAddress-1:0] id_rs2,
  input  logic [RegAddress-1:0] id_rd,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [DataWidth-1:0]  id_rs1_data,
  input  logic [DataWidth-1:0]  id_rs2_data,
  input  logic [DataWidth-1:0]  id_imm,
  input  logic [DataWidth-1:0]  ex_alu_result,
  input  logic [RegAddress-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [DataWidth-1:0]  mem_fwd_data,
  input  logic [RegAddress-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [DataWidth-1:0]  wb_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [DataWidth-1:0]  ex_pc,
  output logic [DataWidth-1:0]  ex_imm,
  output logic [DataWidth-1:0]  ex_rs1_val,
  output logic [DataWidth-1:0]  ex_rs2_val,
  output logic [CtrlWidth-1:0]  ex_ctrl,
  output logic [RegAddress-1:0] ex_rd,
  output logic                  ex_load,
  output logic                  ex_reg_write,
  output logic                  hazard_stall,
  output logic [CntWidth-1:0]   stall_cnt
);
  function automatic logic dep(input logic wr, input logic [RegAddress-1:0] rd,
                               input logic [RegAddress-1:0] src, input logic used);
    return wr && rd == src && src != '0 && used;
  endfunction

  logic dep_ex1, dep_ex2, dep_mem1, dep_mem2, dep_wb1, dep_wb2;
  logic hazard, hold, take;
  logic [DataWidth-1:0] rs1_fwd, rs2_fwd;

  assign dep_ex1  = dep(ex_valid && ex_reg_write, ex_rd, id_rs1, id_rs1_used);
  assign dep_ex2  = dep(ex_valid && ex_reg_write, ex_rd, id_rs2, id_rs2_used);
  assign dep_mem1 = dep(mem_reg_write, mem_rd, id_rs1, id_rs1_used);
  assign dep_mem2 = dep(mem_reg_write, mem_rd, id_rs2, id_rs2_used);
  assign dep_wb1  = dep(wb_reg_write, wb_rd, id_rs1, id_rs1_used);
  assign dep_wb2  = dep(wb_reg_write, wb_rd, id_rs2, id_rs2_used);

  // Without forwarding every in-flight producer blocks the consumer until it retires from WB.
  assign hazard = ForwardEn != 0
    ? id_valid && ex_valid && ex_load && (dep_ex1 || dep_ex2)
    : id_valid && (dep_ex1 || dep_ex2 || dep_mem1 || dep_mem2 || dep_wb1 || dep_wb2);
  assign hazard_stall = hazard && !flush;
  assign hold = ex_valid && !ex_ready;
  assign id_ready = flush || (!hold && !hazard);
  assign take = id_valid && !hazard;

  assign rs1_fwd = id_rs1 == '0 ? '0 : ForwardEn == 0 ? id_rs1_data :
                   dep_ex1 && !ex_load ? ex_alu_result : dep_mem1 ? mem_fwd_data :
                   dep_wb1 ? wb_data : id_rs1_data;
  assign rs2_fwd = id_rs2 == '0 ? '0 : ForwardEn == 0 ? id_rs2_data :
                   dep_ex2 && !ex_load ? ex_alu_result : dep_mem2 ? mem_fwd_data :
                   dep_wb2 ? wb_data : id_rs2_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_ctrl      <= '0;
      ex_rd        <= '0;
      ex_load      <= 1'b0;
      ex_reg_write <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (hazard_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CntWidth'(1);
      if (flush) ex_valid <= 1'b0;
      else if (!hold) begin
        ex_valid <= take;
        if (take) begin
          ex_pc        <= id_pc;
          ex_imm       <= id_imm;
          ex_rs1_val   <= rs1_fwd;
          ex_rs2_val   <= rs2_fwd;
          ex_ctrl      <= id_ctrl;
          ex_rd        <= id_rd;
          ex_load      <= id_load;
          ex_reg_write <= id_reg_write;
        end
      end
    end
  end
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: directed and random checks of a forwarding and a non-forwarding stage against a reference model.
module tb_id_ex_hazard_stage;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic id_valid, id_load, id_rw, u1, u2, mem_rw, wb_rw, flush, ex_ready;
  logic [31:0] id_pc, d1, d2, imm, ex_alu, mem_fwd, wb_d;
  logic [11:0] id_ctrl;
  logic [4:0] rs1, rs2, rd, mem_rd, wb_rd;

  logic ev[2], hs[2], rdy[2], ld_o[2], rw_o[2];
  logic [31:0] pc_o[2], imm_o[2], v1_o[2], v2_o[2];
  logic [11:0] ctrl_o[2];
  logic [4:0] rd_o[2];
  logic [15:0] cnt0;
  logic [1:0] cnt1;

  id_ex_hazard_stage u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(rdy[0]), .id_pc(id_pc), .id_ctrl(id_ctrl),
    .id_load(id_load), .id_reg_write(id_rw), .id_rs1(rs1), .id_rs2(rs2), .id_rd(rd),
    .id_rs1_used(u1), .id_rs2_used(u2), .id_rs1_data(d1), .id_rs2_data(d2), .id_imm(imm),
    .ex_alu_result(ex_alu), .mem_rd(mem_rd), .mem_reg_write(mem_rw), .mem_fwd_data(mem_fwd),
    .wb_rd(wb_rd), .wb_reg_write(wb_rw), .wb_data(wb_d), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ev[0]), .ex_pc(pc_o[0]), .ex_imm(imm_o[0]), .ex_rs1_val(v1_o[0]), .ex_rs2_val(v2_o[0]),
    .ex_ctrl(ctrl_o[0]), .ex_rd(rd_o[0]), .ex_load(ld_o[0]), .ex_reg_write(rw_o[0]),
    .hazard_stall(hs[0]), .stall_cnt(cnt0));

  id_ex_hazard_stage #(.ForwardEn(0), .CntWidth(2)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(rdy[1]), .id_pc(id_pc), .id_ctrl(id_ctrl),
    .id_load(id_load), .id_reg_write(id_rw), .id_rs1(rs1), .id_rs2(rs2), .id_rd(rd),
    .id_rs1_used(u1), .id_rs2_used(u2), .id_rs1_data(d1), .id_rs2_data(d2), .id_imm(imm),
    .ex_alu_result(ex_alu), .mem_rd(mem_rd), .mem_reg_write(mem_rw), .mem_fwd_data(mem_fwd),
    .wb_rd(wb_rd), .wb_reg_write(wb_rw), .wb_data(wb_d), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ev[1]), .ex_pc(pc_o[1]), .ex_imm(imm_o[1]), .ex_rs1_val(v1_o[1]), .ex_rs2_val(v2_o[1]),
    .ex_ctrl(ctrl_o[1]), .ex_rd(rd_o[1]), .ex_load(ld_o[1]), .ex_reg_write(rw_o[1]),
    .hazard_stall(hs[1]), .stall_cnt(cnt1));

  typedef struct packed {
    logic valid, load, rw;
    logic [31:0] pc, imm, v1, v2;
    logic [11:0] ctrl;
    logic [4:0] rd;
    int cnt;
  } st_t;

  st_t st[2];
  int cmax[2] = '{65535, 3};
  int tests = 0, failed = 0;
  logic hs_s[2], rdy_s[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int i);
    return i == 0 ? 64'(cnt0) : 64'(cnt1);
  endfunction

  // Does the instruction in stage stg (0=EX model, 1=MEM, 2=WB) produce register r that ID reads?
  function automatic bit produces(input st_t s, input int stg, input logic [4:0] r, input logic u);
    if (r == 0 || !u) return 0;
    if (stg == 0) return s.valid && s.rw && s.rd == r;
    if (stg == 1) return mem_rw && mem_rd == r;
    return wb_rw && wb_rd == r;
  endfunction

  // Instance 0 forwards; instance 1 only reads the register file.
  function automatic logic [31:0] operand(input st_t s, input int i, input logic [4:0] r,
                                          input logic u, input logic [31:0] rf);
    if (r == 0) return 0;
    if (i == 1) return rf;
    if (produces(s, 0, r, u) && !s.load) return ex_alu;
    if (produces(s, 1, r, u)) return mem_fwd;
    if (produces(s, 2, r, u)) return wb_d;
    return rf;
  endfunction

  function automatic bit blocked(input st_t s, input int i);
    if (!id_valid) return 0;
    if (i == 0) return s.valid && s.load && (produces(s, 0, rs1, u1) || produces(s, 0, rs2, u2));
    for (int g = 0; g < 3; g++)
      if (produces(s, g, rs1, u1) || produces(s, g, rs2, u2)) return 1;
    return 0;
  endfunction

  task automatic check_regs(input int i);
    chk($sformatf("ex_valid[%0d]", i), 64'(ev[i]), 64'(st[i].valid));
    if (st[i].valid) begin
      chk($sformatf("ex_pc[%0d]", i), 64'(pc_o[i]), 64'(st[i].pc));
      chk($sformatf("ex_imm[%0d]", i), 64'(imm_o[i]), 64'(st[i].imm));
      chk($sformatf("ex_rs1_val[%0d]", i), 64'(v1_o[i]), 64'(st[i].v1));
      chk($sformatf("ex_rs2_val[%0d]", i), 64'(v2_o[i]), 64'(st[i].v2));
      chk($sformatf("ex_ctrl[%0d]", i), 64'(ctrl_o[i]), 64'(st[i].ctrl));
      chk($sformatf("ex_rd[%0d]", i), 64'(rd_o[i]), 64'(st[i].rd));
      chk($sformatf("ex_flags[%0d]", i), 64'({ld_o[i], rw_o[i]}), 64'({st[i].load, st[i].rw}));
    end
    chk($sformatf("stall_cnt[%0d]", i), cnt_of(i), 64'(st[i].cnt));
  endtask

  task automatic step();
    bit hz;
    st_t nx[2];
    #3;
    for (int i = 0; i < 2; i++) begin
      hz = blocked(st[i], i);
      hs_s[i] = hs[i];
      rdy_s[i] = rdy[i];
      chk($sformatf("hazard_stall[%0d]", i), 64'(hs[i]), 64'(hz && !flush));
      chk($sformatf("id_ready[%0d]", i), 64'(rdy[i]), 64'(flush || (!(st[i].valid && !ex_ready) && !hz)));
      nx[i] = st[i];
      if (flush) nx[i].valid = 0;
      else if (st[i].valid && !ex_ready) begin end
      else if (hz || !id_valid) nx[i].valid = 0;
      else begin
        nx[i].valid = 1; nx[i].pc = id_pc; nx[i].imm = imm; nx[i].ctrl = id_ctrl;
        nx[i].rd = rd; nx[i].load = id_load; nx[i].rw = id_rw;
        nx[i].v1 = operand(st[i], i, rs1, u1, d1);
        nx[i].v2 = operand(st[i], i, rs2, u2, d2);
      end
      if (hz && !flush && st[i].cnt < cmax[i]) nx[i].cnt++;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      st[i] = nx[i];
      check_regs(i);
    end
  endtask

  task automatic async_reset();
    #2 rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid[%0d]", i), 64'(ev[i]), 0);
      chk($sformatf("rst_payload[%0d]", i),
          64'(pc_o[i] | imm_o[i] | v1_o[i] | v2_o[i] | 32'(ctrl_o[i]) | 32'(rd_o[i]) | 32'(ld_o[i]) | 32'(rw_o[i])), 0);
      chk($sformatf("rst_cnt[%0d]", i), cnt_of(i), 0);
      st[i] = '0;
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_ctrl = 0; id_load = 0; id_rw = 0; rs1 = 0; rs2 = 0; rd = 0;
    u1 = 0; u2 = 0; d1 = 0; d2 = 0; imm = 0; ex_alu = 0; mem_rd = 0; mem_rw = 0; mem_fwd = 0;
    wb_rd = 0; wb_rw = 0; wb_d = 0; flush = 0; ex_ready = 1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] a, input logic ua, input logic [4:0] b,
                       input logic ub, input logic [4:0] dst, input logic w, input logic ld,
                       input logic [31:0] da, input logic [31:0] db);
    id_valid = 1; id_pc = pc; id_ctrl = pc[11:0] ^ 12'hA5A; imm = ~pc; rs1 = a; u1 = ua; rs2 = b; u2 = ub;
    rd = dst; id_rw = w; id_load = ld; d1 = da; d2 = db;
  endtask

  initial begin
    idle();
    st[0] = '0; st[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 2; i++) check_regs(i);
    chk("reset_pc", 64'(pc_o[0]), 0);

    issue(32'h100, 1, 1, 2, 1, 3, 1, 0, 32'h11, 32'h22);
    step();
    chk("add1_valid", 64'(ev[0]), 1);
    chk("add1_rs1", 64'(v1_o[0]), 32'h11);
    chk("add1_rs2", 64'(v2_o[0]), 32'h22);
    issue(32'h104, 4, 1, 5, 1, 6, 1, 0, 32'h44, 32'h55);
    step();
    chk("add2_pc", 64'(pc_o[0]), 32'h104);
    chk("add2_rs1", 64'(v1_o[0]), 32'h44);
    chk("add2_cnt", 64'(cnt0), 0);

    issue(32'h108, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step();
    issue(32'h10c, 3, 1, 0, 0, 8, 1, 0, 32'h99, 0);
    ex_alu = 32'h55;
    step();
    chk("fwd_ex_nostall", 64'(hs_s[0]), 0);
    chk("fwd_ex_rs1", 64'(v1_o[0]), 32'h55);

    ex_alu = 0;
    issue(32'h110, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step();
    issue(32'h114, 0, 0, 7, 1, 0, 1, 0, 0, 32'h1234);
    step();
    chk("lu_stall", 64'(hs_s[0]), 1);
    chk("lu_ready", 64'(rdy_s[0]), 0);
    chk("lu_bubble", 64'(ev[0]), 0);
    mem_rd = 7; mem_rw = 1; mem_fwd = 32'hDEADBEEF;
    step();
    chk("lu_release", 64'(hs_s[0]), 0);
    chk("lu_rs2", 64'(v2_o[0]), 32'hDEADBEEF);
    chk("lu_cnt", 64'(cnt0), 1);

    issue(32'h118, 0, 1, 0, 1, 10, 1, 0, 32'hFFFF, 32'hFFFF);
    ex_alu = 32'hFFFF; mem_rd = 0; mem_rw = 1; mem_fwd = 32'hFFFF; wb_rd = 0; wb_rw = 1; wb_d = 32'hFFFF;
    step();
    chk("x0_nostall", 64'(hs_s[0]), 0);
    chk("x0_rs1", 64'(v1_o[0]), 0);
    chk("x0_rs2", 64'(v2_o[0]), 0);

    idle();
    issue(32'h11c, 1, 1, 2, 1, 11, 1, 0, 1, 2);
    ex_ready = 0;
    repeat (3) begin
      step();
      chk("hold_ready", 64'(rdy_s[0]), 0);
      chk("hold_pc", 64'(pc_o[0]), 32'h118);
    end
    flush = 1;
    step();
    chk("flush_ready", 64'(rdy_s[0]), 1);
    chk("flush_valid", 64'(ev[0]), 0);

    idle();
    async_reset();
    issue(32'h200, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    step();
    chk("nf_prod_valid", 64'(ev[1]), 1);
    issue(32'h204, 9, 1, 0, 0, 12, 1, 0, 32'h77, 0);
    step();
    chk("nf_stall_ex", 64'(hs_s[1]), 1);
    mem_rd = 9; mem_rw = 1;
    step();
    chk("nf_stall_mem", 64'(hs_s[1]), 1);
    mem_rw = 0; wb_rd = 9; wb_rw = 1;
    step();
    chk("nf_stall_wb", 64'(hs_s[1]), 1);
    chk("nf_cnt3", 64'(cnt1), 3);
    step();
    chk("nf_cnt_sat", 64'(cnt1), 3);
    async_reset();
    wb_rw = 0;
    step();
    chk("nf_release", 64'(hs_s[1]), 0);
    chk("nf_rs1", 64'(v1_o[1]), 32'h77);

    for (int n = 0; n < 600; n++) begin
      id_valid = $urandom_range(0, 3) != 0;
      id_pc = $urandom; id_ctrl = 12'($urandom); imm = $urandom; d1 = $urandom; d2 = $urandom;
      id_load = $urandom_range(0, 2) == 0; id_rw = $urandom_range(0, 3) != 0;
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      u1 = $urandom_range(0, 3) != 0; u2 = $urandom_range(0, 1) != 0;
      ex_alu = $urandom; mem_fwd = $urandom; wb_d = $urandom;
      mem_rd = 5'($urandom_range(0, 3)); mem_rw = $urandom_range(0, 1) != 0;
      wb_rd = 5'($urandom_range(0, 3)); wb_rw = $urandom_range(0, 1) != 0;
      flush = $urandom_range(0, 15) == 0; ex_ready = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 99) == 0) async_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
